// File: rtl/muldiv_arbiter.sv
// Round-robin front end that lets several requesters share one iterative
// RV32M multiply/divide unit, one operation in flight at a time.
module muldiv_arbiter #(
    parameter int p_num_reqs = 2,
    parameter int p_ptr_bits = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [p_num_reqs-1:0]      req_val,
    output logic [p_num_reqs-1:0]      req_rdy,
    input  logic [3*p_num_reqs-1:0]    req_op,
    input  logic [32*p_num_reqs-1:0]   req_opa,
    input  logic [32*p_num_reqs-1:0]   req_opb,
    output logic [p_num_reqs-1:0]      resp_val,
    input  logic [p_num_reqs-1:0]      resp_rdy,
    output logic [31:0]                resp_data,
    output logic                       unit_req_val,
    input  logic                       unit_req_rdy,
    output logic [2:0]                 unit_req_op,
    output logic [31:0]                unit_req_opa,
    output logic [31:0]                unit_req_opb,
    input  logic                       unit_resp_val,
    output logic                       unit_resp_rdy,
    input  logic [31:0]                unit_resp_data,
    output logic [p_ptr_bits-1:0]      owner
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [p_ptr_bits-1:0]  r_prio_ptr;
    logic [p_ptr_bits-1:0]  r_owner;
    logic [2:0]             r_op;
    logic [31:0]            r_opa;
    logic [31:0]            r_opb;
    logic [31:0]            r_result;

    logic                   w_grant_found;
    logic [p_ptr_bits-1:0]  w_grant_idx;
    logic [p_ptr_bits-1:0]  w_grant_next;
    logic [p_num_reqs-1:0]  w_grant_onehot;
    logic                   w_req_fire;

    function automatic int wrapIdx(input int base, input int offset);
        return (base + offset) % p_num_reqs;
    endfunction

    // Scan from the priority pointer upward; the first valid requester wins.
    always_comb begin
        w_grant_found  = 1'b0;
        w_grant_idx    = '0;
        w_grant_next   = '0;
        w_grant_onehot = '0;
        for (int k = 0; k < p_num_reqs; k++) begin
            if (!w_grant_found &&
                req_val[p_ptr_bits'(wrapIdx(int'(r_prio_ptr), k))]) begin
                w_grant_found  = 1'b1;
                w_grant_idx    = p_ptr_bits'(wrapIdx(int'(r_prio_ptr), k));
                w_grant_next   = p_ptr_bits'(wrapIdx(int'(r_prio_ptr), k + 1));
                w_grant_onehot = p_num_reqs'(1) << wrapIdx(int'(r_prio_ptr), k);
            end
        end
    end

    assign w_req_fire = (r_state == IDLE) && !rst && w_grant_found;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req_fire)         w_state_nxt = ISSUE;
            ISSUE:   if (unit_req_rdy)       w_state_nxt = WAIT;
            WAIT:    if (unit_resp_val)      w_state_nxt = RESP;
            RESP:    if (resp_rdy[r_owner])  w_state_nxt = IDLE;
            default:                         w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is asserted, even mid-operation.
    always_comb begin
        req_rdy       = w_req_fire ? w_grant_onehot : '0;
        unit_req_val  = !rst && (r_state == ISSUE);
        unit_resp_rdy = !rst && (r_state == WAIT);
        resp_val      = (!rst && (r_state == RESP)) ? (p_num_reqs'(1) << r_owner) : '0;
    end

    assign unit_req_op  = r_op;
    assign unit_req_opa = r_opa;
    assign unit_req_opb = r_opb;
    assign resp_data    = r_result;
    assign owner        = r_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_prio_ptr <= '0;
            r_owner    <= '0;
            r_op       <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_result   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req_fire) begin
                r_owner    <= w_grant_idx;
                r_prio_ptr <= w_grant_next;
                r_op       <= req_op[3*int'(w_grant_idx) +: 3];
                r_opa      <= req_opa[32*int'(w_grant_idx) +: 32];
                r_opb      <= req_opb[32*int'(w_grant_idx) +: 32];
            end
            if ((r_state == WAIT) && unit_resp_val) begin
                r_result <= unit_resp_data;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter: a 2-requester and a 4-requester instance,
// each in front of a fixed-latency (3-cycle) mock RV32M unit.
module tb_muldiv_arbiter;

    logic clk;
    logic rst;

    logic [1:0]   reqVal;
    logic [1:0]   reqRdy;
    logic [5:0]   reqOp;
    logic [63:0]  reqOpa;
    logic [63:0]  reqOpb;
    logic [1:0]   respVal;
    logic [1:0]   respRdy;
    logic [31:0]  respData;
    logic [0:0]   owner;

    logic [3:0]   reqVal4;
    logic [3:0]   reqRdy4;
    logic [11:0]  reqOp4;
    logic [127:0] reqOpa4;
    logic [127:0] reqOpb4;
    logic [3:0]   respVal4;
    logic [3:0]   respRdy4;
    logic [31:0]  respData4;
    logic [1:0]   owner4;

    logic         uReqVal[2];
    logic         uReqRdy[2];
    logic [2:0]   uReqOp[2];
    logic [31:0]  uReqOpa[2];
    logic [31:0]  uReqOpb[2];
    logic         uRespVal[2];
    logic         uRespRdy[2];
    logic [31:0]  uRespData[2];

    logic         mockAccept;
    logic         mockBusy[2];
    logic [1:0]   mockCnt[2];
    logic [31:0]  mockRes[2];

    int checks;
    int failures;

    muldiv_arbiter #(.p_num_reqs(2), .p_ptr_bits(1)) dut (
        .clk(clk), .rst(rst),
        .req_val(reqVal), .req_rdy(reqRdy), .req_op(reqOp),
        .req_opa(reqOpa), .req_opb(reqOpb),
        .resp_val(respVal), .resp_rdy(respRdy), .resp_data(respData),
        .unit_req_val(uReqVal[0]), .unit_req_rdy(uReqRdy[0]), .unit_req_op(uReqOp[0]),
        .unit_req_opa(uReqOpa[0]), .unit_req_opb(uReqOpb[0]),
        .unit_resp_val(uRespVal[0]), .unit_resp_rdy(uRespRdy[0]),
        .unit_resp_data(uRespData[0]), .owner(owner)
    );

    muldiv_arbiter #(.p_num_reqs(4), .p_ptr_bits(2)) dut4 (
        .clk(clk), .rst(rst),
        .req_val(reqVal4), .req_rdy(reqRdy4), .req_op(reqOp4),
        .req_opa(reqOpa4), .req_opb(reqOpb4),
        .resp_val(respVal4), .resp_rdy(respRdy4), .resp_data(respData4),
        .unit_req_val(uReqVal[1]), .unit_req_rdy(uReqRdy[1]), .unit_req_op(uReqOp[1]),
        .unit_req_opa(uReqOpa[1]), .unit_req_opb(uReqOpb[1]),
        .unit_resp_val(uRespVal[1]), .unit_resp_rdy(uRespRdy[1]),
        .unit_resp_data(uRespData[1]), .owner(owner4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference RV32M result used by the mock unit.
    function automatic logic [31:0] mockCompute(input logic [2:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        logic [63:0] p;
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    always_comb begin
        for (int u = 0; u < 2; u++) begin
            uReqRdy[u]   = mockAccept && !mockBusy[u];
            uRespVal[u]  = mockBusy[u] && (mockCnt[u] == 2'd0);
            uRespData[u] = mockRes[u];
        end
    end

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                mockBusy[m] <= 1'b0;
                mockCnt[m]  <= 2'd0;
                mockRes[m]  <= 32'd0;
            end else if (uReqVal[m] && uReqRdy[m]) begin
                mockBusy[m] <= 1'b1;
                mockCnt[m]  <= 2'd2;
                mockRes[m]  <= mockCompute(uReqOp[m], uReqOpa[m], uReqOpb[m]);
            end else if (uRespVal[m] && uRespRdy[m]) begin
                mockBusy[m] <= 1'b0;
            end else if (mockCnt[m] != 2'd0) begin
                mockCnt[m] <= mockCnt[m] - 2'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rstIn, input logic [1:0] valIn,
                                 input logic [1:0] rdyIn);
        rst     = rstIn;
        reqVal  = valIn;
        respRdy = rdyIn;
        #1;
    endtask

    task automatic setReq(input int idx, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        reqOp[3*idx +: 3]   = op;
        reqOpa[32*idx +: 32] = a;
        reqOpb[32*idx +: 32] = b;
    endtask

    task automatic setReq4(input int idx, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        reqOp4[3*idx +: 3]    = op;
        reqOpa4[32*idx +: 32] = a;
        reqOpb4[32*idx +: 32] = b;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        mockAccept = 1'b1;
        reqOp      = '0;
        reqOpa     = '0;
        reqOpb     = '0;
        reqVal4    = '0;
        reqOp4     = '0;
        reqOpa4    = '0;
        reqOpb4    = '0;
        respRdy4   = 4'b1111;
        setReq(0, 3'd0, 32'd7, 32'd6);
        setReq(1, 3'd0, 32'd1, 32'd1);
        applyStimulus(1'b1, 2'b11, 2'b11);

        // Reset held two cycles with both requesters valid.
        for (int c = 0; c < 2; c++) begin
            tick();
            checkOutput("rst_req_rdy", 32'(reqRdy), 32'd0);
            checkOutput("rst_resp_val", 32'(respVal), 32'd0);
            checkOutput("rst_unit_req_val", 32'(uReqVal[0]), 32'd0);
            checkOutput("rst_unit_resp_rdy", 32'(uRespRdy[0]), 32'd0);
        end
        checkOutput("rst_resp_data", respData, 32'd0);
        checkOutput("rst_owner", 32'(owner), 32'd0);
        checkOutput("rst_req_rdy4", 32'(reqRdy4), 32'd0);

        // Single mul 7*6 from req0; cycle N is the handshake cycle.
        tick();
        applyStimulus(1'b0, 2'b11, 2'b11);
        checkOutput("first_grant", 32'(reqRdy), 32'd1);
        reqVal[1] = 1'b0;
        tick();
        applyStimulus(1'b0, 2'b00, 2'b11);
        checkOutput("n1_unit_req_val", 32'(uReqVal[0]), 32'd1);
        checkOutput("n1_unit_req_op", 32'(uReqOp[0]), 32'd0);
        checkOutput("n1_unit_req_opa", uReqOpa[0], 32'd7);
        checkOutput("n1_unit_req_opb", uReqOpb[0], 32'd6);
        checkOutput("n1_req_rdy", 32'(reqRdy), 32'd0);
        tick();
        checkOutput("n2_unit_resp_rdy", 32'(uRespRdy[0]), 32'd1);
        checkOutput("n2_unit_req_val", 32'(uReqVal[0]), 32'd0);
        tick();
        tick();
        checkOutput("n4_resp_val", 32'(respVal), 32'd0);
        tick();
        checkOutput("n5_resp_val", 32'(respVal), 32'd1);
        checkOutput("n5_resp_data", respData, 32'd42);
        tick();
        checkOutput("n6_resp_val", 32'(respVal), 32'd0);

        // Re-reset so the pointer starts at 0, then two competing divides.
        applyStimulus(1'b1, 2'b00, 2'b11);
        tick();
        setReq(0, 3'd4, 32'd100, 32'd7);
        setReq(1, 3'd4, 32'hFFFFFFF7, 32'd2);
        applyStimulus(1'b0, 2'b11, 2'b11);
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 20 && reqRdy == 2'b00; c++) tick();
            checkOutput("rr_grant", 32'(reqRdy), 32'd1 << (g % 2));
            tick();
            checkOutput("rr_owner", 32'(owner), 32'(g % 2));
            for (int c = 0; c < 20 && respVal == 2'b00; c++) tick();
            checkOutput("rr_resp_val", 32'(respVal), 32'd1 << (g % 2));
            checkOutput("rr_resp_data", respData, (g % 2 == 0) ? 32'd14 : 32'hFFFFFFFC);
            tick();
        end
        applyStimulus(1'b0, 2'b00, 2'b11);
        checkOutput("rr_idle_req_rdy", 32'(reqRdy), 32'd0);

        // Backpressure: unit stalls in ISSUE, then req1 stalls in RESP.
        mockAccept = 1'b0;
        setReq(1, 3'd7, 32'hFFFFFFFF, 32'd10);
        setReq(0, 3'd0, 32'd1, 32'd1);
        applyStimulus(1'b0, 2'b10, 2'b01);
        checkOutput("bp_grant", 32'(reqRdy), 32'd2);
        tick();
        applyStimulus(1'b0, 2'b01, 2'b01);
        for (int c = 0; c < 4; c++) begin
            checkOutput("bp_issue_hold", 32'(uReqVal[0]), 32'd1);
            checkOutput("bp_issue_req_rdy", 32'(reqRdy), 32'd0);
            tick();
        end
        mockAccept = 1'b1;
        for (int c = 0; c < 20 && respVal == 2'b00; c++) tick();
        checkOutput("bp_resp_val", 32'(respVal), 32'd2);
        checkOutput("bp_resp_data", respData, 32'd5);
        for (int c = 0; c < 2; c++) begin
            tick();
            checkOutput("bp_resp_hold", 32'(respVal), 32'd2);
            checkOutput("bp_resp_data_hold", respData, 32'd5);
            checkOutput("bp_resp_req_rdy", 32'(reqRdy), 32'd0);
        end
        tick();
        applyStimulus(1'b0, 2'b00, 2'b11);
        checkOutput("bp_release_resp_val", 32'(respVal), 32'd2);
        tick();
        checkOutput("bp_after_resp_val", 32'(respVal), 32'd0);

        // Reset while the unit is busy: the work must vanish without a response.
        setReq(0, 3'd0, 32'd3, 32'd5);
        applyStimulus(1'b0, 2'b01, 2'b11);
        checkOutput("mid_grant", 32'(reqRdy), 32'd1);
        tick();
        applyStimulus(1'b0, 2'b00, 2'b11);
        tick();
        checkOutput("mid_wait", 32'(uRespRdy[0]), 32'd1);
        applyStimulus(1'b1, 2'b00, 2'b11);
        checkOutput("mid_rst_unit_resp_rdy", 32'(uRespRdy[0]), 32'd0);
        checkOutput("mid_rst_resp_val", 32'(respVal), 32'd0);
        tick();
        applyStimulus(1'b0, 2'b00, 2'b11);
        for (int c = 0; c < 6; c++) begin
            checkOutput("mid_no_resp", 32'(respVal), 32'd0);
            tick();
        end
        setReq(1, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        applyStimulus(1'b0, 2'b10, 2'b11);
        checkOutput("post_rst_grant", 32'(reqRdy), 32'd2);
        tick();
        applyStimulus(1'b0, 2'b00, 2'b11);
        for (int c = 0; c < 20 && respVal == 2'b00; c++) tick();
        checkOutput("post_rst_resp_val", 32'(respVal), 32'd2);
        checkOutput("post_rst_resp_data", respData, 32'hFFFFFFFE);
        tick();

        // Four-requester instance with only req2 and req3 active.
        setReq4(2, 3'd0, 32'd3, 32'd4);
        setReq4(3, 3'd5, 32'd20, 32'd3);
        reqVal4 = 4'b1100;
        #1;
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 20 && reqRdy4 == 4'b0000; c++) tick();
            checkOutput("rr4_grant", 32'(reqRdy4), 32'd1 << (2 + g % 2));
            tick();
            checkOutput("rr4_owner", 32'(owner4), 32'(2 + g % 2));
            for (int c = 0; c < 20 && respVal4 == 4'b0000; c++) tick();
            checkOutput("rr4_resp_val", 32'(respVal4), 32'd1 << (2 + g % 2));
            checkOutput("rr4_resp_data", respData4, (g % 2 == 0) ? 32'd12 : 32'd6);
            tick();
        end
        reqVal4 = 4'b0000;
        #1;
        checkOutput("rr4_idle_req_rdy", 32'(reqRdy4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_arbiter.md
# muldiv_arbiter

Round-robin arbiter and sequencer that lets several requesters share one iterative RV32M multiply/divide unit. It accepts at most one operation at a time over per-requester val/rdy interfaces, forwards it to the shared unit, and routes the unit's result back to the requester that issued it. It sits between the execute stage(s) of a processor and the single MulDiv datapath, so `mul`, `mulh`, `mulhu`, `mulhsu`, `div`, `divu`, `rem` and `remu` all funnel through it.

## Interface
- `p_num_reqs`, default 2: number of requesters, 2..4.
- `p_ptr_bits`, default 1: width of the requester index (fixed to 2 if `p_num_reqs` > 2).

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_val`  in  `p_num_reqs`  per-requester request valid.
- `req_rdy`  out  `p_num_reqs`  per-requester request ready (one-hot or zero).
- `req_op`  in  3*`p_num_reqs`  funct3 of the M-ext op, requester i at bits [3i+2:3i].
- `req_opa`, `req_opb`  in  32*`p_num_reqs`  operands, requester i at bits [32i+31:32i].
- `resp_val`  out  `p_num_reqs`  per-requester response valid (one-hot or zero).
- `resp_rdy`  in  `p_num_reqs`  per-requester response ready.
- `resp_data`  out  32  result, shared by all requesters, qualified by `resp_val`.
- `unit_req_val` out 1, `unit_req_rdy` in 1, `unit_req_op` out 3, `unit_req_opa`/`unit_req_opb` out 32: request to the shared unit.
- `unit_resp_val` in 1, `unit_resp_rdy` out 1, `unit_resp_data` in 32: response from the shared unit.
- `owner`  out  `p_ptr_bits`  index of the requester currently being served (debug).

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Grant goes to the first requester with `req_val`=1, scanning from `prio_ptr` upward modulo `p_num_reqs`.
  - `req_rdy` is asserted only at the granted index. This is combinational from `req_val` and `prio_ptr`.
  - On the handshake, capture op, opa, opb and `owner`, set `prio_ptr` = (owner+1) mod `p_num_reqs`, and go to ISSUE.
- **ISSUE:**
  - `unit_req_val`=1 and the unit request fields are driven from the captured registers.
  - When `unit_req_rdy`=1, go to WAIT.
- **WAIT:**
  - `unit_resp_rdy`=1.
  - When `unit_resp_val`=1, capture `unit_resp_data` and go to RESP.
- **RESP:**
  - `resp_val[owner]`=1 and `resp_data` is the captured result.
  - When `resp_rdy[owner]`=1, go to IDLE.
  - `resp_rdy` of any other requester is ignored.
- **Quiet outputs:** `req_rdy`=0 in every state except IDLE. `unit_req_val`, `unit_resp_rdy` and `resp_val` are 0 outside their own state.
- **Operand transparency:** op and operands pass through unmodified. Divide-by-zero and overflow semantics belong to the unit.
- **Requester obligation:** a requester must hold `req_val` and its fields stable until `req_rdy`. The arbiter does not check this.

## Timing
- **Reset values:**
  - State=IDLE, `prio_ptr`=0, `owner`=0, captured registers=0.
  - Every val/rdy output is 0 during the reset cycle, including `req_rdy`.
  - `resp_data`=0.
- **Reset mid-operation:**
  - In-flight work is discarded with no response.
  - `rst` is shared with the unit, which also flushes.
- **Latency:**
  - Requester handshake in cycle N gives `unit_req_val`=1 in cycle N+1.
  - With a unit of fixed latency L (req fire in cycle N+1, resp_val in cycle N+1+L), `resp_val` rises in cycle N+2+L.
  - The minimum turnaround between back-to-back grants is one IDLE cycle after the response handshake.
- **No bypass:**
  - No path is combinational from `unit_*` inputs to requester outputs.
  - `req_val` reaches only `req_rdy`.
- **Simultaneous requests:** resolved purely by `prio_ptr`. The pointer advances only on a grant, not on idle cycles.
- **Single requester:** repeated grants to the same index are allowed. The pointer wraps but the scan still finds it.
- **Withdrawal:** `req_val` dropped in IDLE before a grant has no effect.
- **Backpressure:** the arbiter holds ISSUE or RESP indefinitely while the downstream rdy is low.

## Test plan
- **Reset:** hold `rst` for 2 cycles, all requesters valid.
  - Every rdy/val output is 0 during reset.
  - The first grant after reset goes to requester 0.
- **Single op:** req0 `mul` 7*6 with a 3-cycle mock unit.
  - `unit_req_val` at N+1.
  - `resp_val[0]`=1 with `resp_data`=42 at N+5.
  - `resp_val[1]` stays 0.
- **Round-robin:** both requesters hold `div` ops continuously (req0 100/7, req1 -9/2).
  - Grants alternate 0,1,0,1.
  - Results: req0 gets 14, req1 gets 0xFFFFFFFC (div truncates toward zero).
- **Backpressure:** `unit_req_rdy` low for 4 cycles, then `resp_rdy[1]` low for 3 cycles on a `remu` 0xFFFFFFFF%10.
  - The FSM holds in ISSUE, then in RESP.
  - `resp_data`=5 stays stable.
  - No new `req_rdy` is raised.
- **Reset mid-WAIT:** assert `rst` while the unit is busy.
  - No `resp_val` appears.
  - The next request is served normally.
- **Four requesters** (`p_num_reqs`=4): only req2 and req3 valid.
  - Grants follow 2,3,2,3.
  - `owner` tracks the grant.
  - `resp_val` is one-hot.
